// File: rtl/vigna_bus_mem.sv
// vigna_bus_mem: dual-port (instruction/data) valid/ready memory responder.
// One shared single-ported word array, round-robin arbitration between the
// two initiators, WAIT_CYCLES extra cycles between grant and response, and
// low-lane justified sub-word data.
module vigna_bus_mem #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_dport_q, grant_dport_d;  // 1: data port owns the transaction
  logic        last_dport_q, last_dport_d;    // 1: data port was granted last
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [4:0]    sh;
  logic [3:0]    eff_strb;
  logic [31:0]   eff_wdata;
  logic [31:0]   rd_data;
  logic          pick_dport;
  logic          resp;

  // The instruction port is read-only; its write payload is deliberately dropped.
  logic unused_ipayload;
  assign unused_ipayload = ^{i_wdata, i_wstrb};

  // Decode and lane alignment of the registered request
  always_comb begin
    off       = addr_q - BASE_ADDR;
    in_range  = off < MEM_BYTES;
    idx       = off[AW+1:2];
    sh        = {addr_q[1:0], 3'b000};
    // Lanes pushed above byte 3 fall off: no access spans two words.
    eff_strb  = wstrb_q << addr_q[1:0];
    eff_wdata = wdata_q << sh;
    rd_data   = (in_range && wstrb_q == 4'd0) ? (mem[idx] >> sh) : 32'd0;
  end

  // Responses are pure decodes of RESP so an async reset drops them at once
  always_comb begin
    resp    = (state_q == S_RESP);
    i_ready = resp && !grant_dport_q;
    d_ready = resp &&  grant_dport_q;
    i_rdata = i_ready ? rd_data : 32'd0;
    d_rdata = d_ready ? rd_data : 32'd0;
  end

  // Next-state: arbitration and request capture in IDLE, wait countdown, response
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_dport_d = grant_dport_q;
    last_dport_d  = last_dport_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    // On contention the port that lost last time wins; a lone requester always wins.
    pick_dport    = d_valid && (!i_valid || !last_dport_q);
    case (state_q)
      S_IDLE: begin
        if (i_valid || d_valid) begin
          grant_dport_d = pick_dport;
          last_dport_d  = pick_dport;
          addr_d        = pick_dport ? d_addr  : i_addr;
          wdata_d       = pick_dport ? d_wdata : 32'd0;
          wstrb_d       = pick_dport ? d_wstrb : 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and request registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      grant_dport_q <= 1'b0;
      last_dport_q  <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_dport_q <= grant_dport_d;
      last_dport_q  <= last_dport_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
    end
  end

  // Byte-enabled write, committed at the edge that closes RESP; contents are not reset
  always_ff @(posedge clk) begin
    if (resp && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_strb[b]) mem[idx][8*b +: 8] <= eff_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vigna_bus_mem.sv
// Bench for vigna_bus_mem: transaction-level model + per-cycle compare on the
// main instance (WAIT_CYCLES=1), and latency sweep instances (0, 3, 15).
module tb_vigna_bus_mem;

  localparam int W = 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        i_valid, i_ready, d_valid, d_ready;
  logic [31:0] i_addr, i_rdata, i_wdata, d_addr, d_rdata, d_wdata;
  logic [3:0]  i_wstrb, d_wstrb;

  int total = 0;
  int bad   = 0;

  vigna_bus_mem #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(W)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb)
  );

  // Sweep instances: 16 words based at 0x1000_0000, data port only
  localparam logic [31:0] SBASE = 32'h1000_0000;
  logic [2:0]  sv, sr, sir;
  logic [31:0] sa [3];
  logic [31:0] swd [3];
  logic [31:0] srd [3];
  logic [31:0] sird [3];
  logic [3:0]  sws [3];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    vigna_bus_mem #(.MEM_WORDS(16), .BASE_ADDR(SBASE),
                    .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 15))) u_sw (
      .clk(clk), .resetn(resetn),
      .i_valid(1'b0), .i_ready(sir[g]), .i_addr(32'h0), .i_rdata(sird[g]),
      .i_wdata(32'h0), .i_wstrb(4'h0),
      .d_valid(sv[g]), .d_ready(sr[g]), .d_addr(sa[g]), .d_rdata(srd[g]),
      .d_wdata(swd[g]), .d_wstrb(sws[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model of the main instance ----------------
  logic [31:0] mm [0:1023];
  int          n = 0;          // rising-edge counter
  bit          pend = 0;       // a granted transaction is outstanding
  bit          pdp;            // owner: 1 = data port
  bit          last_d = 0;
  int          resp_at;        // response occupies the cycle after this edge
  logic [31:0] paddr, pwdata;
  logic [3:0]  pwstrb;

  function automatic logic [31:0] exp_rd();
    logic [31:0] o;
    o = paddr;
    if (pwstrb != 4'd0 || o >= 32'd4096) return 32'd0;
    return mm[o[11:2]] >> (8 * int'(paddr[1:0]));
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend   = 0;
      last_d = 0;
    end else begin
      n++;
      if (pend) begin
        if (n == resp_at + 1) begin
          if (paddr < 32'd4096 && pwstrb != 4'd0)
            for (int b = 0; b < 4; b++)
              if (pwstrb[b] && b + int'(paddr[1:0]) < 4)
                mm[paddr[11:2]][8*(b + int'(paddr[1:0])) +: 8] = pwdata[8*b +: 8];
          pend = 0;
        end
      end else if (i_valid || d_valid) begin
        pdp     = (i_valid && d_valid) ? !last_d : d_valid;
        last_d  = pdp;
        paddr   = pdp ? d_addr : i_addr;
        pwdata  = d_wdata;
        pwstrb  = pdp ? d_wstrb : 4'd0;
        resp_at = n + W;
        pend    = 1;
      end
    end
  end

  // Per-cycle compare of every main-instance output against the model
  always @(negedge clk) begin
    bit er_i, er_d;
    er_i = pend && !pdp && (n == resp_at);
    er_d = pend &&  pdp && (n == resp_at);
    chk("i_ready", {31'd0, i_ready}, {31'd0, er_i});
    chk("d_ready", {31'd0, d_ready}, {31'd0, er_d});
    chk("i_rdata", i_rdata, er_i ? exp_rd() : 32'd0);
    chk("d_rdata", d_rdata, er_d ? exp_rd() : 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic xfer(input bit dp, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    if (dp) begin d_valid = 1; d_addr = a; d_wdata = wd; d_wstrb = ws; end
    else    begin i_valid = 1; i_addr = a; i_wdata = wd; i_wstrb = ws; end
    lat = -1; rd = 32'd0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (dp ? d_ready : i_ready) begin lat = k; rd = dp ? d_rdata : i_rdata; end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout port=%0d addr=%h: got no ready expected ready", dp, a);
    end
    @(posedge clk); #1;
    if (dp) d_valid = 0; else i_valid = 0;
  endtask

  task automatic sxfer(input int k, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    sv[k] = 1; sa[k] = a; swd[k] = wd; sws[k] = ws;
    lat = -1; rd = 32'd0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge clk);
      if (sr[k]) begin lat = c; rd = srd[k]; end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL sweep_timeout k=%0d: got no ready expected ready", k);
    end
    @(posedge clk); #1;
    sv[k] = 0;
    @(negedge clk);
    chk("sweep_single_cycle_ready", {31'd0, sr[k]}, 32'd0);
  endtask

  task automatic rst_pulse();
    @(negedge clk); #1 resetn = 0;
    @(negedge clk); #1 resetn = 1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd, rd2;
    int          lat, lat2, wexp;

    resetn = 0;
    i_valid = 0; i_addr = 0; i_wdata = 0; i_wstrb = 0;
    d_valid = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    sv = 0;
    for (int k = 0; k < 3; k++) begin sa[k] = 0; swd[k] = 0; sws[k] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_i_ready", {31'd0, i_ready}, 32'd0);
    chk("reset_d_ready", {31'd0, d_ready}, 32'd0);
    chk("reset_i_rdata", i_rdata, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);
    #1 resetn = 1;

    // Preload through the data port
    xfer(1, 32'd0, 32'hDEADBEEF, 4'hF, rd, lat);
    chk("write_resp_rdata", rd, 32'd0);
    chk("write_latency", lat, 32'd2);
    xfer(1, 32'd4, 32'h11223344, 4'hF, rd, lat);
    xfer(1, 32'd8, 32'hCAFEF00D, 4'hF, rd, lat);

    // Plain instruction read
    xfer(0, 32'd0, 32'd0, 4'd0, rd, lat);
    chk("i_read_word0", rd, 32'hDEADBEEF);
    chk("i_read_latency", lat, 32'd2);

    // Byte store and shifted reads
    xfer(1, 32'd6, 32'h000000AA, 4'b0001, rd, lat);
    xfer(1, 32'd4, 32'd0, 4'd0, rd, lat);
    chk("byte_store_word", rd, 32'h11AA3344);
    xfer(1, 32'd6, 32'd0, 4'd0, rd, lat);
    chk("read_at_6", rd, 32'h000011AA);
    xfer(0, 32'd7, 32'd0, 4'd0, rd, lat);
    chk("i_read_at_7", rd, 32'h00000011);

    // Half-word store at offset 3: upper lane falls off the word
    xfer(1, 32'd7, 32'h0000BBCC, 4'b0011, rd, lat);
    xfer(1, 32'd4, 32'd0, 4'd0, rd, lat);
    chk("clipped_store", rd, 32'hCCAA3344);

    // Out of range
    xfer(1, 32'h0000_1000, 32'd0, 4'd0, rd, lat);
    chk("oor_read", rd, 32'd0);
    chk("oor_latency", lat, 32'd2);
    xfer(1, 32'h0000_1000, 32'hFFFFFFFF, 4'hF, rd, lat);
    xfer(1, 32'd0, 32'd0, 4'd0, rd, lat);
    chk("oor_write_dropped", rd, 32'hDEADBEEF);

    // Instruction port write payload is ignored
    xfer(0, 32'd8, 32'h0, 4'hF, rd, lat);
    chk("i_port_reads_only", rd, 32'hCAFEF00D);
    xfer(1, 32'd8, 32'd0, 4'd0, rd, lat);
    chk("i_port_no_write", rd, 32'hCAFEF00D);

    // Contention right after reset: d first, then i back-to-back
    rst_pulse();
    fork
      xfer(0, 32'd0, 32'd0, 4'd0, rd, lat);
      xfer(1, 32'd4, 32'd0, 4'd0, rd2, lat2);
    join
    chk("cont1_d_latency", lat2, 32'd2);
    chk("cont1_i_latency", lat, 32'd5);
    chk("cont1_i_data", rd, 32'hDEADBEEF);
    chk("cont1_d_data", rd2, 32'hCCAA3344);
    // A lone d grant, then the next pair goes to i first
    xfer(1, 32'd0, 32'd0, 4'd0, rd, lat);
    fork
      xfer(0, 32'd8, 32'd0, 4'd0, rd, lat);
      xfer(1, 32'd0, 32'd0, 4'd0, rd2, lat2);
    join
    chk("cont2_i_latency", lat, 32'd2);
    chk("cont2_d_latency", lat2, 32'd5);
    chk("cont2_i_data", rd, 32'hCAFEF00D);

    // Reset during WAIT of a write to addr 8
    @(posedge clk); #1;
    d_valid = 1; d_addr = 32'd8; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    @(posedge clk); #2;
    resetn = 0;
    #1;
    chk("rst_wait_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_wait_i_ready", {31'd0, i_ready}, 32'd0);
    d_valid = 0;
    @(negedge clk); #1 resetn = 1;
    xfer(1, 32'd8, 32'd0, 4'd0, rd, lat);
    chk("rst_wait_mem2", rd, 32'hCAFEF00D);
    chk("post_reset_latency", lat, 32'd2);

    // Reset during RESP of a write: ready drops asynchronously, write dropped
    @(posedge clk); #1;
    d_valid = 1; d_addr = 32'd8; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    lat = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (d_ready) lat = k;
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL rst_resp_timeout: got no ready expected ready");
    end
    #1 resetn = 0;
    #1;
    chk("rst_resp_d_ready", {31'd0, d_ready}, 32'd0);
    chk("rst_resp_d_rdata", d_rdata, 32'd0);
    d_valid = 0;
    @(negedge clk); #1 resetn = 1;
    xfer(1, 32'd8, 32'd0, 4'd0, rd, lat);
    chk("rst_resp_mem2", rd, 32'hCAFEF00D);

    // Latency sweep: WAIT_CYCLES = 0, 3, 15 on a relocated base
    for (int k = 0; k < 3; k++) begin
      wexp = (k == 0) ? 0 : (k == 1 ? 3 : 15);
      sxfer(k, SBASE + 32'd4, 32'hA5A5_0000 + k, 4'hF, rd, lat);
      chk("sweep_write_latency", lat, 32'(wexp + 1));
      chk("sweep_write_rdata", rd, 32'd0);
      sxfer(k, SBASE + 32'd4, 32'd0, 4'd0, rd, lat);
      chk("sweep_read_latency", lat, 32'(wexp + 1));
      chk("sweep_read_data", rd, 32'hA5A5_0000 + k);
      sxfer(k, SBASE + 32'd5, 32'd0, 4'd0, rd, lat);
      chk("sweep_read_shift", rd, 32'h00A5_A500 + (k >> 8));
      sxfer(k, 32'd4, 32'd0, 4'd0, rd, lat);
      chk("sweep_below_base", rd, 32'd0);
      sxfer(k, SBASE + 32'd64, 32'd0, 4'd0, rd, lat);
      chk("sweep_above_top", rd, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
